button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 198 +++++++++++++++++++
 tb/tb_button_conditioner.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Breakout input front-end: synchronises and debounces the raw buttons and
// the run switch, then turns them into single-cycle game commands.
// Left/right get auto-repeat, throw fires once per press, and everything
// is gated by the debounced run switch.
module button_conditioner #(
    parameter int DEBOUNCE_TICKS = 2,
    parameter int REPEAT_DELAY   = 6,
    parameter int REPEAT_RATE    = 2
) (
    input  logic buttonclk,
    input  logic reset,
    input  logic raw_left,
    input  logic raw_right,
    input  logic raw_throw,
    input  logic raw_start,
    output logic start_level,
    output logic held_left,
    output logic held_right,
    output logic left_pulse,
    output logic right_pulse,
    output logic throw_pulse
);

    // Input lanes: 0 = left, 1 = right, 2 = throw, 3 = start.
    localparam int NUM_IN = 4;

    localparam logic [3:0] DB_LAST    = 4'(DEBOUNCE_TICKS - 1);
    localparam logic [5:0] DELAY_LOAD = 6'(REPEAT_DELAY);
    localparam logic [5:0] RATE_LOAD  = 6'(REPEAT_RATE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT,
        ST_BLOCK
    } rpt_state_t;

    logic [NUM_IN-1:0] raw_vec;
    logic [NUM_IN-1:0] deb_vec;      // current debounced levels (registered)
    logic [2:0]        deb_prev_q;   // debounced levels one tick ago, for edge detection
    logic [1:0]        next_lr;      // debounced left/right levels after this edge
    logic [1:0]        pulse_lr;
    logic              conflict_d;
    logic              throw_pulse_q;

    assign raw_vec = {raw_start, raw_throw, raw_right, raw_left};

    // Per-input synchroniser and stability-counter debounce.
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_deb
        logic       sync1_q;
        logic       sync2_q;
        logic [3:0] cnt_q;
        logic [3:0] cnt_d;
        logic       deb_q;
        logic       deb_d;

        // Count consecutive samples that disagree with the debounced level;
        // flip once the run is long enough, otherwise restart the count.
        always_comb begin
            cnt_d = cnt_q;
            deb_d = deb_q;
            if (sync2_q == deb_q) begin
                cnt_d = 4'd0;
            end else if (cnt_q >= DB_LAST) begin
                deb_d = ~deb_q;
                cnt_d = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end

        // Two-flop synchroniser plus debounce state.
        always_ff @(posedge buttonclk) begin
            if (reset) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                cnt_q   <= 4'd0;
                deb_q   <= 1'b0;
            end else begin
                sync1_q <= raw_vec[gi];
                sync2_q <= sync1_q;
                cnt_q   <= cnt_d;
                deb_q   <= deb_d;
            end
        end

        assign deb_vec[gi] = deb_q;

        if (gi < 2) begin : g_next
            assign next_lr[gi] = deb_d;
        end
    end

    // Remember last tick's debounced levels so a press is seen exactly once.
    always_ff @(posedge buttonclk) begin
        if (reset) begin
            deb_prev_q <= 3'b000;
        end else begin
            deb_prev_q <= deb_vec[2:0];
        end
    end

    // Conflict tracks the debounced levels being loaded this edge, so BLOCK
    // coincides with held_left and held_right both reading 1.
    assign conflict_d = &next_lr;

    // Left/right repeat engines.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rpt
        localparam int OTHER = 1 - gi;

        rpt_state_t state_q;
        rpt_state_t state_d;
        logic [5:0] tick_q;
        logic [5:0] tick_d;
        logic       pulse_q;
        logic       pulse_d;
        logic       rise;

        assign rise = deb_vec[gi] & ~deb_prev_q[gi];

        // Next state: gating beats conflict, conflict beats normal operation.
        always_comb begin
            state_d = state_q;
            tick_d  = tick_q;
            pulse_d = 1'b0;
            if (!start_level) begin
                state_d = ST_IDLE;
                tick_d  = 6'd0;
            end else if (conflict_d) begin
                state_d = ST_BLOCK;
                tick_d  = 6'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rise && !deb_vec[OTHER]) begin
                            pulse_d = 1'b1;
                            state_d = ST_DELAY;
                            tick_d  = DELAY_LOAD;
                        end
                    end
                    ST_BLOCK: begin
                        // Surviving direction resumes with a full delay, no pulse.
                        if (next_lr[gi]) begin
                            state_d = ST_DELAY;
                            tick_d  = DELAY_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        if (!deb_vec[gi]) begin
                            state_d = ST_IDLE;
                            tick_d  = 6'd0;
                        end else if (tick_q <= 6'd1) begin
                            pulse_d = 1'b1;
                            state_d = ST_REPEAT;
                            tick_d  = RATE_LOAD;
                        end else begin
                            tick_d = tick_q - 6'd1;
                        end
                    end
                endcase
            end
        end

        // Repeat engine state and registered pulse.
        always_ff @(posedge buttonclk) begin
            if (reset) begin
                state_q <= ST_IDLE;
                tick_q  <= 6'd0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                tick_q  <= tick_d;
                pulse_q <= pulse_d;
            end
        end

        assign pulse_lr[gi] = pulse_q;
    end

    // One throw per debounced press, only while the run switch is on.
    always_ff @(posedge buttonclk) begin
        if (reset) begin
            throw_pulse_q <= 1'b0;
        end else begin
            throw_pulse_q <= start_level & deb_vec[2] & ~deb_prev_q[2];
        end
    end

    assign held_left   = deb_vec[0];
    assign held_right  = deb_vec[1];
    assign start_level = deb_vec[3];
    assign left_pulse  = pulse_lr[0];
    assign right_pulse = pulse_lr[1];
    assign throw_pulse = throw_pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a scheduled-time model checked every cycle,
// plus directed scenarios with hand-computed pulse edge lists.
module tb_button_conditioner;

    localparam int DB  = 2;
    localparam int DLY = 6;
    localparam int RT  = 2;

    logic buttonclk = 1'b0;
    logic reset     = 1'b1;
    logic raw_left  = 1'b0;
    logic raw_right = 1'b0;
    logic raw_throw = 1'b0;
    logic raw_start = 1'b0;
    logic start_level, held_left, held_right;
    logic left_pulse, right_pulse, throw_pulse;

    int n_cmp  = 0;
    int n_bad  = 0;
    int edge_n = -1;

    // Observed history per edge: 0 left_pulse, 1 right_pulse, 2 throw_pulse, 3 held_left
    bit plog [4][1024];

    button_conditioner #(
        .DEBOUNCE_TICKS(DB),
        .REPEAT_DELAY  (DLY),
        .REPEAT_RATE   (RT)
    ) dut (
        .buttonclk  (buttonclk),
        .reset      (reset),
        .raw_left   (raw_left),
        .raw_right  (raw_right),
        .raw_throw  (raw_throw),
        .raw_start  (raw_start),
        .start_level(start_level),
        .held_left  (held_left),
        .held_right (held_right),
        .left_pulse (left_pulse),
        .right_pulse(right_pulse),
        .throw_pulse(throw_pulse)
    );

    always #5 buttonclk = ~buttonclk;

    // Model state: raw delay line, sample history, debounced levels, and
    // for each direction whether a repeat is scheduled and at which edge.
    logic [1:0]  rawh [4];
    logic [15:0] smph [4];
    logic [3:0]  m_deb;
    logic [3:0]  m_deb_prev;
    bit          m_act [2];
    bit          m_blk [2];
    int          m_next [2];
    logic [5:0]  exp_o;

    always @(posedge buttonclk) begin
        logic [3:0] rv, dold, dnew, rise;
        logic [1:0] pl;
        logic       tp, samp, all_diff;
        logic [5:0] act;
        edge_n = edge_n + 1;
        rv = {raw_start, raw_throw, raw_right, raw_left};
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                rawh[i] = 2'b00;
                smph[i] = 16'h0;
            end
            m_deb      = 4'b0;
            m_deb_prev = 4'b0;
            for (int d = 0; d < 2; d++) begin
                m_act[d]  = 1'b0;
                m_blk[d]  = 1'b0;
                m_next[d] = 0;
            end
            exp_o = 6'b0;
        end else begin
            dold = m_deb;
            for (int i = 0; i < 4; i++) begin
                samp    = rawh[i][1];
                rawh[i] = {rawh[i][0], rv[i]};
                smph[i] = {smph[i][14:0], samp};
                all_diff = 1'b1;
                for (int k = 0; k < DB; k++)
                    if (smph[i][k] == dold[i]) all_diff = 1'b0;
                dnew[i] = all_diff ? ~dold[i] : dold[i];
            end
            rise = dold & ~m_deb_prev;
            for (int d = 0; d < 2; d++) begin
                pl[d] = 1'b0;
                if (!dold[3]) begin
                    m_act[d] = 1'b0;
                    m_blk[d] = 1'b0;
                end else if (dnew[0] && dnew[1]) begin
                    m_act[d] = 1'b0;
                    m_blk[d] = 1'b1;
                end else if (m_blk[d]) begin
                    m_blk[d]  = 1'b0;
                    m_act[d]  = dnew[d];
                    m_next[d] = edge_n + DLY;
                end else if (!dold[d]) begin
                    m_act[d] = 1'b0;
                end else if (!m_act[d]) begin
                    if (rise[d] && !dold[1-d]) begin
                        pl[d]     = 1'b1;
                        m_act[d]  = 1'b1;
                        m_next[d] = edge_n + DLY;
                    end
                end else if (edge_n == m_next[d]) begin
                    pl[d]     = 1'b1;
                    m_next[d] = edge_n + RT;
                end
            end
            tp = dold[3] & rise[2];
            m_deb_prev = dold;
            m_deb      = dnew;
            exp_o = {dnew[3], dnew[0], dnew[1], pl[0], pl[1], tp};
        end
        #1;
        act = {start_level, held_left, held_right, left_pulse, right_pulse, throw_pulse};
        n_cmp = n_cmp + 1;
        if (act !== exp_o) begin
            n_bad = n_bad + 1;
            $display("FAIL outputs edge %0d: got %b expected %b (start,heldL,heldR,L,R,T)",
                     edge_n, act, exp_o);
        end
        if (edge_n < 1024) begin
            plog[0][edge_n] = left_pulse;
            plog[1][edge_n] = right_pulse;
            plog[2][edge_n] = throw_pulse;
            plog[3][edge_n] = held_left;
        end
    end

    task automatic wait_edge(input int e);
        while (edge_n < e) @(negedge buttonclk);
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] pmask(input int w, input int base, input int hi);
        logic [63:0] m = 64'h0;
        for (int r = 0; r <= hi; r++)
            if (base + r < 1024) m[r] = plog[w][base + r];
        return m;
    endfunction

    function automatic logic [63:0] b(input int r);
        return 64'h1 << r;
    endfunction

    initial begin
        int base;
        // Reset held for two edges with every raw input high.
        reset = 1'b1;
        raw_left = 1'b1; raw_right = 1'b1; raw_throw = 1'b1; raw_start = 1'b1;
        wait_edge(0);
        chk("reset_outputs_e0", 64'({start_level, held_left, held_right, left_pulse, right_pulse, throw_pulse}), 64'h0);
        wait_edge(1);
        chk("reset_outputs_e1", 64'({start_level, held_left, held_right, left_pulse, right_pulse, throw_pulse}), 64'h0);
        reset = 1'b0; raw_right = 1'b0;
        base = edge_n + 1;
        wait_edge(base + 8);
        chk("reset_first_left", pmask(0, base, 8), b(4));
        chk("reset_first_throw", pmask(2, base, 8), b(4));
        raw_left = 1'b0; raw_throw = 1'b0;
        wait_edge(edge_n + 12);

        // One-tick glitch on left.
        base = edge_n + 1;
        raw_left = 1'b1;
        wait_edge(base);
        raw_left = 1'b0;
        wait_edge(base + 10);
        chk("glitch_held", pmask(3, base, 10), 64'h0);
        chk("glitch_pulse", pmask(0, base, 10), 64'h0);

        // Hold and repeat.
        base = edge_n + 1;
        raw_left = 1'b1;
        wait_edge(base + 2);
        chk("hold_held_e2", 64'(held_left), 64'h0);
        wait_edge(base + 3);
        chk("hold_held_e3", 64'(held_left), 64'h1);
        wait_edge(base + 19);
        raw_left = 1'b0;
        wait_edge(base + 22);
        chk("hold_held_e22", 64'(held_left), 64'h1);
        wait_edge(base + 23);
        chk("hold_held_e23", 64'(held_left), 64'h0);
        wait_edge(base + 30);
        chk("hold_pulses", pmask(0, base, 30),
            b(4) | b(10) | b(12) | b(14) | b(16) | b(18) | b(20) | b(22));
        chk("hold_held_span", pmask(3, base, 30), (b(23) - 64'h1) & ~(b(3) - 64'h1));
        wait_edge(edge_n + 5);

        // Conflict, then right released.
        base = edge_n + 1;
        raw_left = 1'b1; raw_right = 1'b1;
        wait_edge(base + 9);
        raw_right = 1'b0;
        wait_edge(base + 26);
        chk("conflict_left", pmask(0, base, 26), b(19) | b(21) | b(23) | b(25));
        chk("conflict_right", pmask(1, base, 26), 64'h0);
        raw_left = 1'b0;
        wait_edge(edge_n + 8);

        // Right press released so the debounced fall lands on a repeat edge.
        base = edge_n + 1;
        raw_right = 1'b1;
        wait_edge(base + 10);
        raw_right = 1'b0;
        wait_edge(base + 20);
        chk("right_fall_edge", pmask(1, base, 20), b(4) | b(10) | b(12) | b(14));

        // Throw: long hold, release, re-press.
        base = edge_n + 1;
        raw_throw = 1'b1;
        wait_edge(base + 19);
        raw_throw = 1'b0;
        wait_edge(base + 29);
        raw_throw = 1'b1;
        wait_edge(base + 45);
        raw_throw = 1'b0;
        chk("throw_pulses", pmask(2, base, 45), b(4) | b(34));
        wait_edge(edge_n + 8);

        // Gating by the run switch.
        raw_start = 1'b0;
        wait_edge(edge_n + 6);
        chk("gate_start_low", 64'(start_level), 64'h0);
        base = edge_n + 1;
        raw_right = 1'b1; raw_throw = 1'b1;
        wait_edge(base + 8);
        raw_right = 1'b0; raw_throw = 1'b0;
        wait_edge(base + 14);
        raw_left = 1'b1;
        wait_edge(base + 22);
        raw_start = 1'b1;
        wait_edge(base + 40);
        chk("gate_start_high", 64'(start_level), 64'h1);
        chk("gate_left", pmask(0, base, 40), 64'h0);
        chk("gate_right", pmask(1, base, 40), 64'h0);
        chk("gate_throw", pmask(2, base, 40), 64'h0);
        raw_left = 1'b0;
        wait_edge(edge_n + 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d, expected completion", edge_n);
        $fatal(1, "timeout");
    end

endmodule
